// File: rtl/vga_pkg.sv
// Shared types and constants for the push-button conditioning logic.
package vga_pkg;

   // Per-channel auto-repeat state.
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t;

   // Bit positions of the board buttons within btn_raw.
   localparam int unsigned BTN_C = 0;
   localparam int unsigned BTN_U = 1;
   localparam int unsigned BTN_L = 2;
   localparam int unsigned BTN_R = 3;
   localparam int unsigned BTN_D = 4;

   // Default timing at 100 MHz.
   localparam int unsigned DEF_NUM_BTN         = 5;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
   localparam int unsigned DEF_REPEAT_DELAY    = 40_000_000;  // 400 ms
   localparam int unsigned DEF_REPEAT_PERIOD   = 65_536;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchronizer, debouncer and press/auto-repeat strobe FSM.
module btn_channel
   import vga_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_step
);

   localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned RCNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));

   localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

   logic [1:0]        sync_q, sync_d;
   logic              stable_q, stable_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic              level_q, level_d;
   btn_state_t        state_q, state_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic              press_q, press_d;
   logic              step_q, step_d;

   // Synchronizer shift and debounce: accept a new level only after it has been
   // seen on every cycle of a full DEBOUNCE_CYCLES window.
   always_comb begin
      sync_d   = {sync_q[0], btn_raw};
      stable_d = stable_q;
      dcnt_d   = '0;
      if (sync_q[1] != stable_q) begin
         if (dcnt_q == DCNT_LAST) begin
            stable_d = sync_q[1];
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end
      level_d = stable_q;
   end

   // Repeat FSM runs off the registered level, so the press lands the cycle after
   // btn_level rises; a low level always wins over a due repeat.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      press_d = 1'b0;
      step_d  = 1'b0;
      if (!level_q) begin
         state_d = IDLE;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // Only reachable with level low, so level high here is a rising edge.
               state_d = DELAY;
               rcnt_d  = '0;
               press_d = 1'b1;
               step_d  = 1'b1;
            end
            DELAY: begin
               if (rcnt_q == DELAY_LAST) begin
                  state_d = REPEAT;
                  rcnt_d  = '0;
                  step_d  = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
            REPEAT: begin
               if (rcnt_q == PERIOD_LAST) begin
                  rcnt_d = '0;
                  step_d = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         dcnt_q   <= '0;
         level_q  <= 1'b0;
         state_q  <= IDLE;
         rcnt_q   <= '0;
         press_q  <= 1'b0;
         step_q   <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         dcnt_q   <= dcnt_d;
         level_q  <= level_d;
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
         press_q  <= press_d;
         step_q   <= step_d;
      end
   end

   assign btn_level = level_q;
   assign btn_press = press_q;
   assign btn_step  = step_q;

endmodule

// File: rtl/btn_debounce_repeat.sv
// Push-button conditioning: NUM_BTN independent debounce + auto-repeat channels.
module btn_debounce_repeat
   import vga_pkg::*;
#(
   parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_step
);

   // One channel per button; channels share nothing but clock and reset.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clk_100MHz(clk_100MHz),
         .reset     (reset),
         .btn_raw   (btn_raw[i]),
         .btn_level (btn_level[i]),
         .btn_press (btn_press[i]),
         .btn_step  (btn_step[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Self-checking bench: expected pulses are queued from stimulus timing, then
// popped and compared as the DUT emits them.
module tb_btn_debounce_repeat;
   import vga_pkg::*;

   localparam int unsigned NB  = 5;
   localparam int unsigned DEB = 4;
   localparam int unsigned RD  = 10;
   localparam int unsigned RP  = 3;
   localparam int          LAT = DEB + 2;   // pin edge to level change

   typedef struct packed {
      int cyc;
      int ch;
   } ev_t;

   logic          clk_100MHz;
   logic          reset;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_step;

   int            vectors;
   int            miscompares;
   string         tname;
   ev_t           step_q[$];
   ev_t           press_q[$];
   logic [NB-1:0] pat[$];
   logic [NB-1:0] lvl_log[0:63];

   btn_debounce_repeat #(
      .NUM_BTN        (NB),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk_100MHz(clk_100MHz),
      .reset     (reset),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .btn_press (btn_press),
      .btn_step  (btn_step)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   function automatic int ev_before(ev_t a, int c, int ch);
      return (a.cyc < c || (a.cyc == c && a.ch < ch)) ? 1 : 0;
   endfunction

   task automatic ins_step(input int c, input int ch);
      ev_t e;
      int  i = 0;
      e.cyc = c;
      e.ch  = ch;
      while (i < step_q.size() && ev_before(step_q[i], c, ch) != 0) i++;
      step_q.insert(i, e);
   endtask

   task automatic ins_press(input int c, input int ch);
      ev_t e;
      int  i = 0;
      e.cyc = c;
      e.ch  = ch;
      while (i < press_q.size() && ev_before(press_q[i], c, ch) != 0) i++;
      press_q.insert(i, e);
   endtask

   // Pin on channel ch high from cycle p up to (not incl.) cycle r; record the
   // pulses expected before cycle n. Level is high from p+LAT to r+LAT-1; a
   // pulse at cycle t needs the level high on cycle t-1.
   task automatic push_hold(input int ch, input int p, input int r, input int n);
      int t;
      t = p + LAT + 1;
      if (t < n) begin
         ins_press(t, ch);
         ins_step(t, ch);
      end
      t = t + RD;
      while (t < n && t <= r + LAT) begin
         ins_step(t, ch);
         t = t + RP;
      end
   endtask

   task automatic fill_pat(input int n, input logic [NB-1:0] v);
      pat.delete();
      for (int k = 0; k < n; k++) pat.push_back(v);
   endtask

   // Cycle k = sample #1 after clock edge k; pat[k] is on the pin before edge k.
   task automatic run_cycles(input int n);
      ev_t e;
      for (int k = 0; k < n; k++) begin
         btn_raw = (k < pat.size()) ? pat[k] : '0;
         @(posedge clk_100MHz);
         #1;
         lvl_log[k] = btn_level;
         for (int ch = 0; ch < NB; ch++) begin
            if (btn_press[ch]) begin
               vectors++;
               if (press_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL %s press: got pulse ch%0d cycle %0d, required none",
                           tname, ch, k);
               end else begin
                  e = press_q.pop_front();
                  if (e.cyc !== k || e.ch !== ch) begin
                     miscompares++;
                     $display("FAIL %s press: got ch%0d cycle %0d, required ch%0d cycle %0d",
                              tname, ch, k, e.ch, e.cyc);
                  end
               end
            end
            if (btn_step[ch]) begin
               vectors++;
               if (step_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL %s step: got pulse ch%0d cycle %0d, required none",
                           tname, ch, k);
               end else begin
                  e = step_q.pop_front();
                  if (e.cyc !== k || e.ch !== ch) begin
                     miscompares++;
                     $display("FAIL %s step: got ch%0d cycle %0d, required ch%0d cycle %0d",
                              tname, ch, k, e.ch, e.cyc);
                  end
               end
            end
         end
      end
      btn_raw = '0;
      vectors++;
      if (press_q.size() != 0 || step_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s missing: got %0d press / %0d step unseen, required 0 / 0",
                  tname, press_q.size(), step_q.size());
         press_q.delete();
         step_q.delete();
      end
   endtask

   task automatic check_level(input int k, input logic [NB-1:0] exp);
      vectors++;
      if (lvl_log[k] !== exp) begin
         miscompares++;
         $display("FAIL %s level@%0d: got %b, required %b", tname, k, lvl_log[k], exp);
      end
   endtask

   task automatic check_outs_zero(input string what);
      vectors++;
      if (btn_level !== '0 || btn_press !== '0 || btn_step !== '0) begin
         miscompares++;
         $display("FAIL %s %s: got level %b press %b step %b, required all 0",
                  tname, what, btn_level, btn_press, btn_step);
      end
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      btn_raw = '0;
      repeat (2) @(posedge clk_100MHz);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tname = "reset";
      reset   = 1'b1;
      btn_raw = '0;
      @(posedge clk_100MHz);
      #1;
      check_outs_zero("during_reset");
      do_reset();
      fill_pat(12, '0);
      run_cycles(12);
      for (int k = 0; k < 12; k++) check_level(k, '0);
   endtask

   task automatic test_clean_press();
      logic [NB-1:0] v;
      tname = "clean_press";
      do_reset();
      v = '0;
      v[BTN_U] = 1'b1;
      fill_pat(8, v);
      push_hold(BTN_U, 0, 8, 20);
      run_cycles(20);
      check_level(LAT - 1, '0);
      check_level(LAT, v);
      check_level(LAT + 7, v);
      check_level(LAT + 8, '0);
   endtask

   task automatic test_bounce();
      tname = "bounce";
      do_reset();
      pat.delete();
      for (int k = 0; k < 30; k++) begin
         pat.push_back((k < 20 && (k % 4) != 3) ? NB'(1 << BTN_L) : '0);
      end
      run_cycles(30);
      for (int k = 0; k < 30; k++) check_level(k, '0);
   endtask

   task automatic test_auto_repeat();
      logic [NB-1:0] v;
      tname = "auto_repeat";
      do_reset();
      v = '0;
      v[BTN_R] = 1'b1;
      fill_pat(40, v);
      push_hold(BTN_R, 0, 40, 50);
      run_cycles(50);
      check_level(LAT, v);
      check_level(40 + LAT - 1, v);
      check_level(40 + LAT, '0);
   endtask

   // Level falls on cycle 16, exactly when the first repeat would fire at 17.
   task automatic test_release_race();
      logic [NB-1:0] v;
      tname = "release_race";
      do_reset();
      v = '0;
      v[BTN_R] = 1'b1;
      pat.delete();
      for (int k = 0; k < 55; k++) pat.push_back((k < 10 || (k >= 20 && k < 45)) ? v : '0);
      push_hold(BTN_R, 0, 10, 55);
      push_hold(BTN_R, 20, 45, 55);
      run_cycles(55);
      check_level(16, '0);
      check_level(26, v);
   endtask

   task automatic test_simultaneous();
      logic [NB-1:0] v;
      tname = "simultaneous";
      do_reset();
      v = '0;
      v[BTN_C] = 1'b1;
      v[BTN_D] = 1'b1;
      fill_pat(25, v);
      push_hold(BTN_C, 0, 25, 35);
      push_hold(BTN_D, 0, 25, 35);
      run_cycles(35);
      check_level(LAT, v);
   endtask

   task automatic test_reset_mid_hold();
      logic [NB-1:0] v;
      tname = "reset_mid_hold";
      do_reset();
      v = '0;
      v[BTN_R] = 1'b1;
      fill_pat(21, v);
      push_hold(BTN_R, 0, 1000, 21);
      run_cycles(21);
      btn_raw = v;
      #3;
      reset = 1'b1;
      #1;
      check_outs_zero("async_assert");
      @(posedge clk_100MHz);
      #1;
      check_outs_zero("held_in_reset");
      reset = 1'b0;
      fill_pat(15, v);
      push_hold(BTN_R, 0, 1000, 15);
      run_cycles(15);
      check_level(LAT - 1, '0);
      check_level(LAT, v);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      btn_raw     = '0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_release_race();
      test_simultaneous();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/btn_debounce_repeat.md
Name: btn_debounce_repeat

Overview:
- Conditions the raw push-button pins (BTNU/BTND/BTNL/BTNR/BTNC) before they reach the sprite position-update logic.
- Per button: synchronizes the pin, debounces it, and emits a one-cycle step pulse on press, then auto-repeat pulses while the button is held.
- Replaces the free-running 16-bit delay gate; the position logic moves one pixel per step pulse.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); must be >= 2.
- REPEAT_DELAY, 40_000_000, cycles from the press pulse to the first repeat pulse (400 ms); must be >= 2.
- REPEAT_PERIOD, 65_536, cycles between successive repeat pulses; must be >= 2.

Ports:
- clk_100MHz, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- btn_raw, input, NUM_BTN, asynchronous raw button pins; bit i is channel i.
- btn_level, output, NUM_BTN, debounced button level.
- btn_press, output, NUM_BTN, one-cycle pulse on each debounced rising edge.
- btn_step, output, NUM_BTN, btn_press OR repeat pulse; this is the movement strobe.

Behaviour:
- Reset:
  - All synchronizer flops, stable levels, counters, FSMs and outputs go to 0 / IDLE.
  - Takes effect immediately (asynchronous assertion); no pulse is emitted after reset is released unless the pin is pressed and held.
- Synchronizer: two flops per bit; sync = second stage.
- Debounce (per channel), with stable level s and counter dcnt, width $clog2(DEBOUNCE_CYCLES):
  - If sync == s: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: s <= sync, dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count; s never changes on it.
- btn_level = s, registered.
- Latency, pin edge to btn_level change: 2 + DEBOUNCE_CYCLES cycles when the pin holds its level throughout.
- Repeat FSM (per channel), counter rcnt sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE: rcnt <= 0. On s rising (s==1, previous s==0): press pulse next cycle, go to DELAY.
  - DELAY: rcnt increments. At rcnt == REPEAT_DELAY-1: repeat pulse, rcnt <= 0, go to REPEAT.
  - REPEAT: rcnt increments. At rcnt == REPEAT_PERIOD-1: repeat pulse, rcnt <= 0, stay in REPEAT.
  - Any state with s==0: go to IDLE, rcnt <= 0, no pulse that cycle (release wins over a coincident repeat).
- Output timing:
  - btn_press and btn_step are registered.
  - btn_press asserts exactly one cycle, the cycle after btn_level rises.
  - btn_step asserts on that same cycle and on every repeat cycle.
  - First repeat follows the press by REPEAT_DELAY cycles; later repeats are spaced REPEAT_PERIOD cycles apart.
- Independence: channels never interact. Simultaneous presses produce simultaneous pulses; priority resolution among buttons belongs to the consumer.
- Re-press: a release followed by a press always restarts from IDLE, giving a fresh press pulse and the full REPEAT_DELAY.
- Reset mid-hold: all outputs drop to 0 asynchronously. After release of reset, a still-held pin is re-debounced (2 + DEBOUNCE_CYCLES cycles), then yields a press pulse.
- No counter ever wraps: each is cleared at its terminal value or on leaving its state.

Decomposition:
- Shared package vga_pkg:
  - typedef enum logic [1:0] {IDLE, DELAY, REPEAT} btn_state_t.
  - Button index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4.
  - Default timing constants.
- Sub-module btn_channel: one synchronizer + debouncer + repeat FSM, same parameters minus NUM_BTN, 1-bit ports.
- Top block instantiates NUM_BTN channels in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTN=5):
- Clean press: hold btn_raw[1] from cycle 0 -> btn_level[1]=1 at cycle 6; btn_press[1] and btn_step[1] high only at cycle 7; other bits stay 0.
- Bounce: toggle btn_raw[2] with 3-cycle pulses separated by 1-cycle gaps for 20 cycles, then release -> btn_level[2] never rises and no pulse appears.
- Auto-repeat: hold btn_raw[3] for 40 cycles -> btn_step[3] at cycles 7, 17, 20, 23, 26, ...; btn_press[3] only at cycle 7.
- Release races repeat: release the pin so btn_level falls on the cycle a repeat is due -> no pulse; FSM in IDLE; re-press gives press pulse and full 10-cycle delay.
- Simultaneous: press bits 0 and 4 in the same cycle -> identical, cycle-aligned btn_step on both.
- Async reset mid-REPEAT: assert reset between clock edges -> all outputs 0 immediately; pin still held after release -> press pulse 7 cycles later.
